// File: rtl/img_bus_if.sv
// Initiator/responder bus bundle for the image-memory port: chip select, command, data and ack/err.
interface img_bus_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              bus_cs_n;
  logic              bus_we_i;
  logic [ADDR_W-1:0] bus_addr_i;
  logic [DATA_W-1:0] bus_wdata_i;
  logic [DATA_W-1:0] bus_rdata_o;
  logic              bus_ack_o;
  logic              bus_err_o;

  modport master (
    output bus_cs_n, bus_we_i, bus_addr_i, bus_wdata_i,
    input  bus_rdata_o, bus_ack_o, bus_err_o
  );

  modport slave (
    input  bus_cs_n, bus_we_i, bus_addr_i, bus_wdata_i,
    output bus_rdata_o, bus_ack_o, bus_err_o
  );
endinterface

// File: rtl/img_bus_resp.sv
// Wait-state memory responder: one registered ack pulse WAIT_CYCLES+1 cycles after chip select,
// err on out-of-range access, completed read/write counters.
module img_bus_resp #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  img_bus_if.slave    bus,
  output logic [15:0] rd_cnt_o,
  output logic [15:0] wr_cnt_o
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        wcnt, wcnt_nxt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              enter_ack;
  logic              mem_we;
  logic              ack_nxt, err_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic [15:0]       rd_cnt_nxt, wr_cnt_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    enter_ack  = 1'b0;
    // With zero wait states the access completes on the sampling edge, so use the live bus.
    acc_we     = (state == IDLE) ? bus.bus_we_i    : we_q;
    acc_addr   = (state == IDLE) ? bus.bus_addr_i  : addr_q;
    acc_wdata  = (state == IDLE) ? bus.bus_wdata_i : wdata_q;
    idx        = acc_addr[IDX_W-1:0];
    in_range   = ({{(32-ADDR_W){1'b0}}, acc_addr} < 32'(DEPTH));

    case (state)
      IDLE: begin
        if (!bus.bus_cs_n) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = ACK;
            enter_ack = 1'b1;
          end else begin
            state_nxt = WAIT;
            wcnt_nxt  = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (bus.bus_cs_n) begin
          state_nxt = IDLE;
          wcnt_nxt  = 4'd0;
        end else if (wcnt == 4'd0) begin
          state_nxt = ACK;
          enter_ack = 1'b1;
        end else begin
          wcnt_nxt = wcnt - 4'd1;
        end
      end
      ACK:     state_nxt = RELEASE;
      RELEASE: if (bus.bus_cs_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    mem_we     = enter_ack && in_range && acc_we;
    ack_nxt    = enter_ack;
    err_nxt    = enter_ack && !in_range;
    rdata_nxt  = (enter_ack && in_range && !acc_we) ? mem[idx] : '0;
    rd_cnt_nxt = (enter_ack && in_range && !acc_we) ? rd_cnt_o + 16'd1 : rd_cnt_o;
    wr_cnt_nxt = mem_we ? wr_cnt_o + 16'd1 : wr_cnt_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wcnt            <= 4'd0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      bus.bus_ack_o   <= 1'b0;
      bus.bus_err_o   <= 1'b0;
      bus.bus_rdata_o <= '0;
      rd_cnt_o        <= 16'd0;
      wr_cnt_o        <= 16'd0;
    end else begin
      state           <= state_nxt;
      wcnt            <= wcnt_nxt;
      if (state == IDLE && !bus.bus_cs_n) begin
        we_q    <= bus.bus_we_i;
        addr_q  <= bus.bus_addr_i;
        wdata_q <= bus.bus_wdata_i;
      end
      bus.bus_ack_o   <= ack_nxt;
      bus.bus_err_o   <= err_nxt;
      bus.bus_rdata_o <= rdata_nxt;
      rd_cnt_o        <= rd_cnt_nxt;
      wr_cnt_o        <= wr_cnt_nxt;
    end
  end

  // Storage carries no reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= acc_wdata;
  end

endmodule

// File: doc/img_bus_resp.md
IMG_BUS_RESP -- requirements
Module: img_bus_resp

Interface
Parameters:
REQ-001 SHALL have parameter DATA_W, default 32, bus data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10, bus word-address width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of implemented memory words (DEPTH <= 2^ADDR_W).
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before ack (range 0..15).

Ports:
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port bus_cs_n, input, 1, initiator chip select, active-low.
REQ-008 SHALL have port bus_we_i, input, 1, 1 = write, 0 = read; qualified by bus_cs_n low.
REQ-009 SHALL have port bus_addr_i, input, ADDR_W, word address.
REQ-010 SHALL have port bus_wdata_i, input, DATA_W, write data.
REQ-011 SHALL have port bus_rdata_o, output, DATA_W, read data; valid only while bus_ack_o = 1.
REQ-012 SHALL have port bus_ack_o, output, 1, one-cycle transfer-complete pulse to initiator.
REQ-013 SHALL have port bus_err_o, output, 1, qualifies bus_ack_o: access was out of range.
REQ-014 SHALL have port rd_cnt_o, output, 16, completed in-range read count.
REQ-015 SHALL have port wr_cnt_o, output, 16, completed in-range write count.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, ACK, RELEASE; all outputs registered.
REQ-017 IDLE: bus_cs_n sampled 0 -> latch addr/we/wdata; go WAIT with wait counter = WAIT_CYCLES-1, or go ACK directly if WAIT_CYCLES = 0.
REQ-018 WAIT: counter decrements each cycle; at 0 go ACK; addr/we/wdata SHALL come only from the latched copies, never live inputs.
REQ-019 WAIT: bus_cs_n sampled 1 (abort) -> go IDLE; no memory write, no ack, counters unchanged.
REQ-020 On the edge entering ACK: in-range write updates mem[addr]; in-range read loads bus_rdata_o = mem[addr].
REQ-021 bus_ack_o SHALL be 1 for exactly the one cycle in ACK, else 0; latency from first edge sampling bus_cs_n low to ack high = WAIT_CYCLES+1 cycles.
REQ-022 ACK -> RELEASE unconditionally; RELEASE holds until bus_cs_n sampled 1, then IDLE; no second ack while cs_n stays low after ack.
REQ-023 Out-of-range (addr >= DEPTH): ack issued on normal timing with bus_err_o = 1; write discarded; bus_rdata_o = 0; counters unchanged.
REQ-024 bus_err_o SHALL be 0 whenever bus_ack_o = 0.
REQ-025 bus_rdata_o SHALL return to 0 in all cycles outside ACK.
REQ-026 rd_cnt_o / wr_cnt_o increment by 1 on each in-range ack of that type; wrap 0xFFFF -> 0x0000.
REQ-027 Read of an address written earlier SHALL return the last written value; same-transaction read/write hazard does not exist (one access per transaction).

Reset
REQ-028 rst_n low SHALL force state = IDLE, bus_ack_o = 0, bus_err_o = 0, bus_rdata_o = 0, rd_cnt_o = 0, wr_cnt_o = 0, wait counter = 0.
REQ-029 Reset mid-transaction SHALL abort it with no ack and no pending write; memory contents unspecified after reset.
REQ-030 After rst_n deasserts, a cs_n already low SHALL be treated as a new request from IDLE.

Verification
REQ-031 WAIT_CYCLES=2: write addr 0x005 data 0xA5A5_0001, cs_n held low until ack -> ack 3 cycles after cs_n sampled low, err=0, wr_cnt_o=1.
REQ-032 Read addr 0x005 after REQ-031 -> bus_rdata_o = 0xA5A5_0001 in ack cycle, 0 next cycle, rd_cnt_o=1.
REQ-033 cs_n held low 4 cycles past ack -> exactly one ack pulse; cs_n high then low again -> second ack on normal latency.
REQ-034 DEPTH=1024, ADDR_W=11, write addr 0x400 -> ack with err=1, wr_cnt_o unchanged, read 0x400 returns 0 with err=1.
REQ-035 cs_n raised during WAIT -> no ack, mem[addr] unchanged; rst_n pulsed during WAIT of a write -> no ack, all outputs 0.
REQ-036 WAIT_CYCLES=0: back-to-back READ, READ, WRITE from initiator dropping cs_n one cycle after ack -> ack 1 cycle after each request, wr_cnt_o=1, rd_cnt_o=2.
